// File: rtl/vec_arb_pkg.sv
// Shared constants and types for the vector round-robin arbiter.
package vec_arb_pkg;
  localparam int VEC_W    = 3;
  localparam int NREQ_DEF = 3;
  // Wide enough for any legal NREQ (2..8), so out_src is always 3 bits.
  localparam int PTR_W    = 3;

  typedef logic [VEC_W-1:0] vec_t;
  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/vec_rr_arbiter_if.sv
// Request/response bundle between requesters, arbiter and consumer.
interface vec_rr_arbiter_if import vec_arb_pkg::*; #(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [VEC_W*NREQ-1:0] req_vec;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  vec_t                  outv;
  logic                  o2, o1, o0;
  ptr_t                  out_src;
  logic [CNT_W-1:0]      xfer_cnt;

  modport master (
    output req_valid, req_vec, out_ready,
    input  req_ready, out_valid, outv, o2, o1, o0, out_src, xfer_cnt
  );
  modport slave (
    input  req_valid, req_vec, out_ready,
    output req_ready, out_valid, outv, o2, o1, o0, out_src, xfer_cnt
  );
endinterface

// File: rtl/vec_rr_arbiter_rr_pick.sv
// Cyclic first-set search over a valid mask starting at ptr.
module rr_pick import vec_arb_pkg::*; #(
  parameter int N = NREQ_DEF
) (
  input  logic [N-1:0] valid,
  input  ptr_t         ptr,
  output logic [N-1:0] gnt,
  output ptr_t         idx,
  output logic         any
);
  logic [N-1:0]   rot;
  logic [PTR_W:0] sum;

  always_comb begin
    // Rotate so bit 0 is requester ptr; the lowest set bit is the winner.
    rot = N'({valid, valid} >> ptr);
    any = 1'b0;
    sum = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (PTR_W+1)'(k);
        any = 1'b1;
      end
    end
    if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
    idx = sum[PTR_W-1:0];
    gnt = '0;
    for (int i = 0; i < N; i++) gnt[i] = any && (idx == PTR_W'(i));
  end
endmodule

// File: rtl/vec_rr_arbiter.sv
// Round-robin arbiter feeding one registered 3-bit vector slot.
module vec_rr_arbiter import vec_arb_pkg::*; #(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             resetn,
  vec_rr_arbiter_if.slave bus
);
  logic [NREQ-1:0][VEC_W-1:0] vecs;
  logic [NREQ-1:0]            gnt;
  ptr_t                       idx, rr_ptr, ptr_nxt;
  logic                       any, ld;
  vec_t                       sel;
  vec_t                       outv_q;
  ptr_t                       src_q;
  logic                       ov_q;
  logic [CNT_W-1:0]           cnt_q;

  assign vecs = bus.req_vec;
  assign ld   = !ov_q || bus.out_ready;

  rr_pick #(.N(NREQ)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .gnt   (gnt),
    .idx   (idx),
    .any   (any)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) sel |= vecs[i] & {VEC_W{gnt[i]}};
  end

  assign ptr_nxt = (idx == PTR_W'(NREQ-1)) ? '0 : idx + 1'b1;

  // Held low during reset so nothing is consumed that the slot will drop.
  assign bus.req_ready = (ld && resetn) ? gnt : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ov_q   <= 1'b0;
      outv_q <= '0;
      src_q  <= '0;
      rr_ptr <= '0;
      cnt_q  <= '0;
    end else if (ld) begin
      if (any) begin
        ov_q   <= 1'b1;
        outv_q <= sel;
        src_q  <= idx;
        rr_ptr <= ptr_nxt;
        cnt_q  <= cnt_q + 1'b1;
      end else begin
        ov_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.outv      = outv_q;
  assign bus.o2        = outv_q[2];
  assign bus.o1        = outv_q[1];
  assign bus.o0        = outv_q[0];
  assign bus.out_src   = src_q;
  assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_vec_rr_arbiter.sv
// Directed table-driven bench for vec_rr_arbiter plus multi-cycle corner sequences.
module tb_vec_rr_arbiter;
  import vec_arb_pkg::*;
  localparam int NREQ  = 3;
  localparam int CNT_W = 8;
  localparam logic [8:0] V0 = 9'b100_010_001;
  localparam logic [8:0] V1 = 9'b110_010_001;
  localparam logic [8:0] VB = 9'b011_101_001;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  vec_rr_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();
  vec_rr_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot(input string nm, input logic ov, input logic [2:0] v,
                          input logic [2:0] src, input logic [7:0] cnt);
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({nm, ".outv"}, 32'(bus.outv), 32'(v));
    chk({nm, ".o2o1o0"}, 32'({bus.o2, bus.o1, bus.o0}), 32'(v));
    chk({nm, ".out_src"}, 32'(bus.out_src), 32'(src));
    chk({nm, ".xfer_cnt"}, 32'(bus.xfer_cnt), 32'(cnt));
  endtask

  typedef struct {
    logic [2:0] valid;
    logic [8:0] vec;
    logic       ordy;
    logic [2:0] e_rdy;
    logic       e_ov;
    logic [2:0] e_outv;
    logic [2:0] e_src;
    logic [7:0] e_cnt;
  } row_t;

  row_t tbl[11];

  initial begin
    tbl[0]  = '{3'b111, V0, 1'b1, 3'b001, 1'b1, 3'b001, 3'd0, 8'd1};
    tbl[1]  = '{3'b111, V0, 1'b1, 3'b010, 1'b1, 3'b010, 3'd1, 8'd2};
    tbl[2]  = '{3'b111, V0, 1'b1, 3'b100, 1'b1, 3'b100, 3'd2, 8'd3};
    tbl[3]  = '{3'b100, V1, 1'b1, 3'b100, 1'b1, 3'b110, 3'd2, 8'd4};
    tbl[4]  = '{3'b111, V0, 1'b1, 3'b001, 1'b1, 3'b001, 3'd0, 8'd5};
    tbl[5]  = '{3'b000, V0, 1'b1, 3'b000, 1'b0, 3'b001, 3'd0, 8'd5};
    tbl[6]  = '{3'b001, V0, 1'b0, 3'b001, 1'b1, 3'b001, 3'd0, 8'd6};
    tbl[7]  = '{3'b111, V0, 1'b0, 3'b000, 1'b1, 3'b001, 3'd0, 8'd6};
    tbl[8]  = '{3'b011, V0, 1'b1, 3'b010, 1'b1, 3'b010, 3'd1, 8'd7};
    tbl[9]  = '{3'b001, V0, 1'b1, 3'b001, 1'b1, 3'b001, 3'd0, 8'd8};
    tbl[10] = '{3'b101, V0, 1'b1, 3'b100, 1'b1, 3'b100, 3'd2, 8'd9};

    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_vec   = V0;
    bus.out_ready = 1'b0;
    #1;
    chk_slot("reset", 1'b0, 3'b000, 3'd0, 8'd0);
    chk("reset.req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    resetn = 1'b1;
    #1;

    for (int i = 0; i < 11; i++) begin
      bus.req_valid = tbl[i].valid;
      bus.req_vec   = tbl[i].vec;
      bus.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("row%0d.req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
      tick();
      chk_slot($sformatf("row%0d", i), tbl[i].e_ov, tbl[i].e_outv, tbl[i].e_src, tbl[i].e_cnt);
    end

    // Backpressure: slot holds 101 from src 1, then stalls three cycles.
    bus.req_valid = 3'b010;
    bus.req_vec   = VB;
    bus.out_ready = 1'b1;
    #1;
    chk("bp.load.req_ready", 32'(bus.req_ready), 32'b010);
    tick();
    chk_slot("bp.load", 1'b1, 3'b101, 3'd1, 8'd10);
    bus.req_valid = 3'b111;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp.stall%0d.req_ready", c), 32'(bus.req_ready), 32'd0);
      tick();
      chk_slot($sformatf("bp.stall%0d", c), 1'b1, 3'b101, 3'd1, 8'd10);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release.req_ready", 32'(bus.req_ready), 32'b100);
    tick();
    chk_slot("bp.release", 1'b1, 3'b011, 3'd2, 8'd11);

    // Asynchronous reset between edges with a transfer pending.
    bus.req_valid = 3'b111;
    bus.req_vec   = V0;
    #2;
    resetn = 1'b0;
    #1;
    chk_slot("midreset", 1'b0, 3'b000, 3'd0, 8'd0);
    chk("midreset.req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk_slot("midreset.edge", 1'b0, 3'b000, 3'd0, 8'd0);
    resetn = 1'b1;
    #1;
    chk("postreset.req_ready", 32'(bus.req_ready), 32'b001);
    tick();
    chk_slot("postreset", 1'b1, 3'b001, 3'd0, 8'd1);

    // Counter wrap: 256 transfers from reset return xfer_cnt to 0.
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    bus.req_valid = 3'b001;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 255; n++) tick();
    chk("wrap.255", 32'(bus.xfer_cnt), 32'd255);
    tick();
    chk("wrap.256", 32'(bus.xfer_cnt), 32'd0);
    tick();
    chk_slot("wrap.257", 1'b1, 3'b001, 3'd0, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
